pbus_master: RTL and testbench

- FPGA-side initiator for the RPi-style parallel byte bus: bus_clk, bus_rnw, 8-bit bidirectional data.
- Generates the sync preamble, then strobes write bytes out or read bytes in, with software-style slow clocking.
- Used to drive the FPGA responder in simulation and on FPGA-to-FPGA links.
- Command/stream interface on the fabric side; tristate buffer lives in the top level.

---
 rtl/pbus_master.sv | 185 ++++++++++++++++++
 tb/tb_pbus_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_master.sv
// pbus_master: parallel byte bus initiator with sync preamble, slow-clocked write/read bursts and bus turnaround
module pbus_master #(
   parameter int HALF_PERIOD = 8,
   parameter int SYNC_HOLD   = 8,
   parameter int TURNAROUND  = 4
) (
   input  logic       clk_100mhz,
   input  logic       reset,
   input  logic       cmd_start,
   input  logic       cmd_rnw,
   input  logic       cmd_sync,
   input  logic [7:0] cmd_len,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       done,
   output logic       bus_clk,
   output logic       bus_rnw,
   output logic [7:0] bus_data_out,
   output logic       bus_data_oe,
   input  logic [7:0] bus_data_in
);
   localparam int MAXV = (HALF_PERIOD > SYNC_HOLD) ?
                         ((HALF_PERIOD > TURNAROUND) ? HALF_PERIOD : TURNAROUND) :
                         ((SYNC_HOLD > TURNAROUND) ? SYNC_HOLD : TURNAROUND);
   localparam int TW = $clog2(MAXV + 1);
   localparam logic [TW-1:0] HP_END = TW'(HALF_PERIOD - 1);
   localparam logic [TW-1:0] SH_END = TW'(SYNC_HOLD - 1);
   localparam logic [TW-1:0] TA_END = TW'(TURNAROUND - 1);

   typedef enum logic [3:0] {
      IDLE, SYNC_B8, SYNC_8B, WR_LOAD, WR_LOW, WR_HIGH,
      TURN_RD, RD_LOW, RD_HIGH, TURN_WR, FINISH
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [7:0]    count;
   logic          phase;
   logic [7:0]    sync1;
   logic [7:0]    sync2;
   logic          hp_end;
   logic          sh_end;
   logic          ta_end;

   assign hp_end   = timer == HP_END;
   assign sh_end   = timer == SH_END;
   assign ta_end   = timer == TA_END;
   assign wr_ready = state == WR_LOAD;

   // two-flop synchronizer for the pad data seen during reads
   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus_data_in;
         sync2 <= sync1;
      end
   end

   // burst sequencer; phase splits each turnaround into its oe step and its rnw step
   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         timer        <= '0;
         count        <= '0;
         phase        <= 1'b0;
         bus_clk      <= 1'b1;
         bus_rnw      <= 1'b0;
         bus_data_oe  <= 1'b1;
         bus_data_out <= '0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         timer    <= timer + TW'(1);
         rd_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               timer       <= '0;
               phase       <= 1'b0;
               bus_clk     <= 1'b1;
               bus_rnw     <= 1'b0;
               bus_data_oe <= 1'b1;
               if (cmd_start) begin
                  count <= cmd_len;
                  busy  <= 1'b1;
                  if (cmd_rnw) begin
                     bus_data_oe <= 1'b0;
                     state       <= TURN_RD;
                  end else if (cmd_sync) begin
                     bus_data_out <= 8'hB8;
                     state        <= SYNC_B8;
                  end else begin
                     bus_clk <= 1'b0;
                     state   <= WR_LOAD;
                  end
               end
            end
            SYNC_B8: if (sh_end) begin
               timer        <= '0;
               bus_data_out <= 8'h8B;
               state        <= SYNC_8B;
            end
            SYNC_8B: if (sh_end) begin
               timer   <= '0;
               bus_clk <= 1'b0;
               state   <= WR_LOAD;
            end
            WR_LOAD: begin
               timer <= '0;
               if (wr_valid) begin
                  bus_data_out <= wr_data;
                  state        <= WR_LOW;
               end
            end
            WR_LOW: if (hp_end) begin
               timer   <= '0;
               bus_clk <= 1'b1;
               state   <= WR_HIGH;
            end
            WR_HIGH: if (hp_end) begin
               timer <= '0;
               if (count == 8'd0) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  count   <= count - 8'd1;
                  bus_clk <= 1'b0;
                  state   <= WR_LOAD;
               end
            end
            TURN_RD: if (ta_end) begin
               timer <= '0;
               phase <= ~phase;
               if (!phase) bus_rnw <= 1'b1;
               else begin
                  bus_clk <= 1'b0;
                  state   <= RD_LOW;
               end
            end
            RD_LOW: if (hp_end) begin
               timer   <= '0;
               bus_clk <= 1'b1;
               state   <= RD_HIGH;
            end
            RD_HIGH: if (hp_end) begin
               timer    <= '0;
               rd_data  <= sync2;
               rd_valid <= 1'b1;
               if (count == 8'd0) begin
                  bus_rnw <= 1'b0;
                  state   <= TURN_WR;
               end else begin
                  count   <= count - 8'd1;
                  bus_clk <= 1'b0;
                  state   <= RD_LOW;
               end
            end
            TURN_WR: if (ta_end) begin
               timer <= '0;
               phase <= ~phase;
               if (!phase) bus_data_oe <= 1'b1;
               else begin
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            FINISH: begin
               timer   <= '0;
               busy    <= 1'b0;
               bus_clk <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pbus_master.sv
// tb_pbus_master: scoreboard bench with a behavioural bus responder for pbus_master
module tb_pbus_master;
   localparam int HP = 8;
   localparam int SH = 8;
   localparam int TA = 4;

   logic       clk_100mhz = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_start = 1'b0;
   logic       cmd_rnw = 1'b0;
   logic       cmd_sync = 1'b0;
   logic [7:0] cmd_len = 8'd0;
   logic [7:0] wr_data = 8'd0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic       done;
   logic       bus_clk;
   logic       bus_rnw;
   logic [7:0] bus_data_out;
   logic       bus_data_oe;
   logic [7:0] bus_data_in;
   logic [7:0] resp_data = 8'd0;

   int compared = 0;
   int mismatched = 0;
   logic [7:0] exp_wr[$];
   logic [7:0] exp_rd[$];
   int burst_edges = 0;
   int b8_cyc = 0;
   int x8b_cyc = 0;
   int done_total = 0;
   int rd_total = 0;
   int both_drive = 0;
   int quiet = 0;
   int resp_idx = 0;
   logic prev_bclk = 1'b1;
   logic prev_busy = 1'b0;
   logic prev_rnw = 1'b0;
   logic prev_oe = 1'b1;

   pbus_master #(.HALF_PERIOD(HP), .SYNC_HOLD(SH), .TURNAROUND(TA)) dut (
      .clk_100mhz(clk_100mhz), .reset(reset), .cmd_start(cmd_start), .cmd_rnw(cmd_rnw),
      .cmd_sync(cmd_sync), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
      .bus_clk(bus_clk), .bus_rnw(bus_rnw), .bus_data_out(bus_data_out),
      .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   assign bus_data_in = bus_data_oe ? bus_data_out : resp_data;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor and responder: sync detect, write sampling on bus_clk rise, read data on bus_clk fall
   always @(negedge clk_100mhz) begin
      if (busy && !prev_busy) begin
         burst_edges = 0;
         b8_cyc = 0;
         x8b_cyc = 0;
      end
      if (busy && bus_clk && bus_data_oe && !bus_rnw && burst_edges == 0) begin
         if (bus_data_out == 8'hB8 && x8b_cyc == 0) b8_cyc++;
         if (bus_data_out == 8'h8B && b8_cyc > 0) x8b_cyc++;
      end
      if (bus_clk && !prev_bclk) begin
         burst_edges++;
         if (busy && !bus_rnw && bus_data_oe) begin
            chk("wr_byte_expected", exp_wr.size() > 0 ? 1 : 0, 1);
            if (exp_wr.size() > 0) chk("wr_byte", bus_data_out, exp_wr.pop_front());
         end
      end
      if (rd_valid) begin
         rd_total++;
         chk("rd_byte_expected", exp_rd.size() > 0 ? 1 : 0, 1);
         if (exp_rd.size() > 0) chk("rd_byte", rd_data, exp_rd.pop_front());
      end
      if (done) done_total++;
      if (bus_data_oe && bus_rnw) both_drive++;
      if (!reset) begin
         if (bus_rnw && !prev_rnw) chk("ta_oe_before_rnw", quiet >= TA ? 1 : 0, 1);
         if (bus_data_oe && !prev_oe) chk("ta_oe_after_rnw", quiet >= TA ? 1 : 0, 1);
      end
      quiet = (!bus_data_oe && !bus_rnw) ? quiet + 1 : 0;
      if (!bus_rnw) resp_idx = 0;
      else if (prev_bclk && !bus_clk) begin
         resp_data = 8'(resp_idx);
         resp_idx++;
      end
      prev_bclk = bus_clk;
      prev_busy = busy;
      prev_rnw = bus_rnw;
      prev_oe = bus_data_oe;
   end

   task automatic check_idle();
      chk("rst_bus_clk", bus_clk, 1);
      chk("rst_bus_rnw", bus_rnw, 0);
      chk("rst_oe", bus_data_oe, 1);
      chk("rst_data_out", bus_data_out, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
   endtask

   task automatic start_cmd(input logic rnw, input logic sync, input logic [7:0] len);
      @(negedge clk_100mhz);
      cmd_rnw = rnw;
      cmd_sync = sync;
      cmd_len = len;
      cmd_start = 1'b1;
      @(negedge clk_100mhz);
      cmd_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      wr_data = b;
      wr_valid = 1'b1;
      while (!wr_ready && t < 2000) begin
         @(negedge clk_100mhz);
         t++;
      end
      if (t >= 2000) chk("wr_ready_timeout", 0, 1);
      @(posedge clk_100mhz);
      #1 wr_valid = 1'b0;
   endtask

   task automatic wait_done(input bit inject);
      int t = 0;
      @(negedge clk_100mhz);
      while (!done && t < 20000) begin
         @(negedge clk_100mhz);
         t++;
      end
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 1);
      chk("rnw_at_done", bus_rnw, 0);
      chk("oe_at_done", bus_data_oe, 1);
      if (inject) begin
         cmd_rnw = 1'b1;
         cmd_sync = 1'b0;
         cmd_len = 8'd9;
         cmd_start = 1'b1;
      end
      @(negedge clk_100mhz);
      cmd_start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int r0;
      int hi;
      int t;
      logic [7:0] stall_bytes[4];
      #1 reset = 1'b1;
      repeat (3) @(negedge clk_100mhz);
      check_idle();
      reset = 1'b0;

      // 256-byte write with sync preamble
      for (int i = 0; i < 256; i++) exp_wr.push_back(8'(i));
      d0 = done_total;
      start_cmd(1'b0, 1'b1, 8'd255);
      for (int i = 0; i < 256; i++) send_byte(8'(i));
      wait_done(1'b0);
      chk("w256_edges", burst_edges, 256);
      chk("w256_b8_cycles", b8_cyc, SH);
      chk("w256_8b_cycles", x8b_cyc, SH);
      chk("w256_left", exp_wr.size(), 0);
      chk("w256_done_count", done_total - d0, 1);

      // 256-byte read, responder returns 0..255
      for (int i = 0; i < 256; i++) exp_rd.push_back(8'(i));
      r0 = rd_total;
      start_cmd(1'b1, 1'b0, 8'd255);
      wait_done(1'b0);
      chk("r256_count", rd_total - r0, 256);
      chk("r256_left", exp_rd.size(), 0);
      chk("r256_edges", burst_edges, 256);
      chk("r256_both_drive", both_drive, 0);

      // 4-byte write with a 50-cycle stall before the second byte
      stall_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      foreach (stall_bytes[i]) exp_wr.push_back(stall_bytes[i]);
      start_cmd(1'b0, 1'b0, 8'd3);
      send_byte(stall_bytes[0]);
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_100mhz);
         if (i >= 20 && bus_clk) hi++;
      end
      chk("stall_clk_high_cycles", hi, 0);
      chk("stall_wr_ready", wr_ready, 1);
      chk("stall_edges", burst_edges, 1);
      for (int i = 1; i < 4; i++) send_byte(stall_bytes[i]);
      wait_done(1'b0);
      chk("stall_edges_total", burst_edges, 4);
      chk("stall_left", exp_wr.size(), 0);

      // starts while busy and on the done cycle are ignored
      for (int i = 0; i < 4; i++) exp_wr.push_back(8'hA0 + 8'(i));
      d0 = done_total;
      r0 = rd_total;
      start_cmd(1'b0, 1'b0, 8'd3);
      send_byte(8'hA0);
      send_byte(8'hA1);
      start_cmd(1'b1, 1'b0, 8'd200);
      send_byte(8'hA2);
      send_byte(8'hA3);
      wait_done(1'b1);
      chk("ign_edges", burst_edges, 4);
      chk("ign_left", exp_wr.size(), 0);
      repeat (20) @(negedge clk_100mhz);
      chk("ign_still_idle", busy, 0);
      chk("ign_rnw", bus_rnw, 0);
      chk("ign_done_count", done_total - d0, 1);
      chk("ign_no_reads", rd_total - r0, 0);
      exp_wr.push_back(8'h5A);
      start_cmd(1'b0, 1'b0, 8'd0);
      send_byte(8'h5A);
      wait_done(1'b0);
      chk("single_edges", burst_edges, 1);
      chk("single_left", exp_wr.size(), 0);

      // reset during a read at byte 100
      for (int i = 0; i < 256; i++) exp_rd.push_back(8'(i));
      r0 = rd_total;
      d0 = done_total;
      start_cmd(1'b1, 1'b0, 8'd255);
      t = 0;
      while (rd_total - r0 < 100 && t < 5000) begin
         @(negedge clk_100mhz);
         t++;
      end
      chk("rst_reached_byte100", rd_total - r0, 100);
      #2 reset = 1'b1;
      #1 check_idle();
      exp_rd.delete();
      repeat (5) @(negedge clk_100mhz);
      reset = 1'b0;
      repeat (5) @(negedge clk_100mhz);
      chk("rst_no_done", done_total - d0, 0);
      chk("rst_reads", rd_total - r0, 100);

      // full write after reset
      for (int i = 0; i < 256; i++) exp_wr.push_back(8'(255 - i));
      start_cmd(1'b0, 1'b1, 8'd255);
      for (int i = 0; i < 256; i++) send_byte(8'(255 - i));
      wait_done(1'b0);
      chk("post_edges", burst_edges, 256);
      chk("post_b8_cycles", b8_cyc, SH);
      chk("post_8b_cycles", x8b_cyc, SH);
      chk("post_left", exp_wr.size(), 0);
      chk("both_drive_total", both_drive, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
